// File: rtl/display_7s_scan_pkg.sv
// Shared definitions for the 7-segment scan driver: display word field
// offsets, the per-slot scan state and a small anode helper.
package display_7s_scan_pkg;

  localparam int DIS_DIGIT_W   = 10;
  localparam int DIS_SEG_LSB   = 0;
  localparam int DIS_DP_BIT    = 7;
  localparam int DIS_EN_BIT    = 8;
  localparam int DIS_BLINK_BIT = 9;
  localparam int DIS_DIGITS    = 8;

  localparam int DIS_WORD_W = DIS_DIGIT_W * DIS_DIGITS;
  localparam int DIG_IDX_W  = $clog2(DIS_DIGITS);

  // All cathodes / anodes released (active-low drive).
  localparam logic [7:0] DARK = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_e;

  // Active-low one-hot anode pattern selecting digit k.
  function automatic logic [DIS_DIGITS-1:0] anode_sel_n(input logic [DIG_IDX_W-1:0] k);
    return ~(DIS_DIGITS'(1) << k);
  endfunction

endpackage

// File: rtl/display_7s_digit_fmt.sv
// Combinational formatter for one 10-bit digit field: decides whether the
// digit may light and produces its active-low cathode pattern.
module display_7s_digit_fmt
  import display_7s_scan_pkg::*;
(
  input  logic [DIS_DIGIT_W-1:0] field_i,
  input  logic                   blink_phase_i,
  input  logic                   dis_en_i,
  output logic                   lit_o,
  output logic [7:0]             seg_o
);

  // Lit needs global enable, digit enable, and not being in the blink-off phase.
  always_comb begin
    lit_o = dis_en_i
          & field_i[DIS_EN_BIT]
          & ~(field_i[DIS_BLINK_BIT] & blink_phase_i);
    seg_o = ~{field_i[DIS_DP_BIT], field_i[DIS_SEG_LSB +: 7]};
  end

endmodule

// File: rtl/display_7s_scan.sv
// Time-multiplexed scan driver for an 8-digit common-anode 7-segment display.
// Each frame snapshots the display word, then visits digits 0..7, each slot
// starting with a blanking gap before the digit is driven.
module display_7s_scan
  import display_7s_scan_pkg::*;
#(
  parameter int DIGIT_TICKS  = 100000,
  parameter int BLANK_TICKS  = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIS_WORD_W-1:0] dis_data,
  input  logic                  dis_en,
  output logic [DIS_DIGITS-1:0] an,
  output logic [7:0]            seg,
  output logic                  frame_start
);

  localparam int TICK_W = $clog2(DIGIT_TICKS);
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TICK_W-1:0]    TICK_LAST  = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [TICK_W-1:0]    BLANK_LAST = TICK_W'(BLANK_TICKS - 1);
  localparam logic [FRM_W-1:0]     FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [DIG_IDX_W-1:0] DIG_LAST   = DIG_IDX_W'(DIS_DIGITS - 1);

  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [DIG_IDX_W-1:0] digit_q, digit_d;
  scan_state_e          state_q, state_d;
  logic [FRM_W-1:0]     frm_q, frm_d;
  logic                 phase_q, phase_d;
  logic [DIS_DIGITS-1:0][DIS_DIGIT_W-1:0] snap_q, snap_d;
  logic [DIS_DIGITS-1:0] an_q, an_d;
  logic [7:0]           seg_q, seg_d;
  logic                 fs_q, fs_d;

  logic tick_wrap;
  logic load;
  logic fmt_lit;
  logic [7:0] fmt_seg;

  assign tick_wrap = (tick_q == TICK_LAST);
  assign load      = (digit_q == '0) && (tick_q == '0);

  display_7s_digit_fmt u_fmt (
    .field_i       (snap_q[digit_q]),
    .blink_phase_i (phase_q),
    .dis_en_i      (dis_en),
    .lit_o         (fmt_lit),
    .seg_o         (fmt_seg)
  );

  // Slot tick and digit index counters, snapshot load and blink timing.
  always_comb begin
    tick_d  = tick_q;
    digit_d = digit_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    snap_d  = snap_q;
    if (tick_wrap) begin
      tick_d  = '0;
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_IDX_W'(1);
    end else begin
      tick_d = tick_q + TICK_W'(1);
    end
    if (load) begin
      snap_d = dis_data;
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end
  end

  // Slot state: blank at the start of every slot, on for the remainder.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (!tick_wrap && tick_q == BLANK_LAST) state_d = ST_ON;
      ST_ON:    if (tick_wrap) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Pin drive for the next cycle; dark unless the current digit may light.
  always_comb begin
    an_d  = {DIS_DIGITS{1'b1}};
    seg_d = DARK;
    fs_d  = load;
    if (state_q == ST_ON && fmt_lit) begin
      an_d  = anode_sel_n(digit_q);
      seg_d = fmt_seg;
    end
  end

  // State registers with synchronous reset; outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q  <= '0;
      digit_q <= '0;
      state_q <= ST_BLANK;
      frm_q   <= '0;
      phase_q <= 1'b0;
      snap_q  <= '0;
      an_q    <= {DIS_DIGITS{1'b1}};
      seg_q   <= DARK;
      fs_q    <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      digit_q <= digit_d;
      state_q <= state_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fs_q    <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;

endmodule
